// File: rtl/countdown_timer.sv
// Seconds-remaining countdown timer for the OLED timer display.
// clk/reset(async low) in; start/pause/load/add_pulse control; time_left and flags out.
module countdown_timer #(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned DEFAULT_SECONDS = 120,
   parameter int unsigned MAX_SECONDS     = 5999,
   parameter int unsigned WARN_SECONDS    = 30,
   parameter int unsigned ADD_SECONDS     = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        add_pulse,
   output logic [15:0] time_left,
   output logic        running,
   output logic        tick,
   output logic        warning,
   output logic        expired,
   output logic        expired_pulse
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] P_LAST  = PW'(CLK_HZ - 1);
   localparam logic [15:0]   T_DEF   = 16'(DEFAULT_SECONDS);
   localparam logic [16:0]   T_MAX17 = 17'(MAX_SECONDS);
   localparam logic [15:0]   T_WARN  = 16'(WARN_SECONDS);
   localparam logic [16:0]   T_ADD17 = 17'(ADD_SECONDS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   state_t        r_state, w_state_nx;
   logic [PW-1:0] r_presc, w_presc_nx;
   logic [15:0]   r_time, w_time_nx;
   logic          r_tick, w_tick_nx;
   logic          r_xp, w_xp_nx;

   logic          w_wrap;
   logic [15:0]   w_base;
   logic [16:0]   w_sum;

   function automatic logic [15:0] sat16(input logic [16:0] v);
      return (v > T_MAX17) ? T_MAX17[15:0] : v[15:0];
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_presc <= '0;
         r_time  <= T_DEF;
         r_tick  <= 1'b0;
         r_xp    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_presc <= w_presc_nx;
         r_time  <= w_time_nx;
         r_tick  <= w_tick_nx;
         r_xp    <= w_xp_nx;
      end
   end

   // A second boundary only counts while RUNNING; it still completes in the
   // cycle a pause is sampled, since the state is RUNNING during that cycle.
   assign w_wrap = (r_state == RUNNING) && (r_presc == P_LAST);
   assign w_base = w_wrap ? (r_time - 16'd1) : r_time;
   assign w_sum  = {1'b0, w_base} + T_ADD17;

   always_comb begin
      w_state_nx = r_state;
      w_presc_nx = r_presc;
      w_time_nx  = r_time;
      w_tick_nx  = 1'b0;
      w_xp_nx    = 1'b0;
      if (load) begin
         w_time_nx  = sat16({1'b0, load_value});
         w_presc_nx = '0;
         w_state_nx = IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start && (r_time != 16'd0)) begin
                  w_state_nx = RUNNING;
                  w_presc_nx = '0;
               end
            end
            RUNNING: begin
               if (pause) w_state_nx = PAUSED;
               w_presc_nx = w_wrap ? '0 : r_presc + 1'b1;
            end
            PAUSED: begin
               // Prescaler is kept so the partial second survives the pause.
               if (start && !pause) w_state_nx = RUNNING;
            end
            EXPIRED: begin
            end
            default: w_state_nx = IDLE;
         endcase
         if (w_wrap) begin
            w_tick_nx = 1'b1;
            w_time_nx = w_base;
         end
         if (add_pulse && (r_state != EXPIRED)) begin
            w_time_nx = sat16(w_sum);
         end
         // A bonus arriving with the last tick rescues the countdown.
         if (w_wrap && (r_time == 16'd1) && !add_pulse) begin
            w_state_nx = EXPIRED;
            w_xp_nx    = 1'b1;
         end
      end
   end

   assign time_left     = r_time;
   assign tick          = r_tick;
   assign expired_pulse = r_xp;
   assign running       = (r_state == RUNNING);
   assign expired       = (r_state == EXPIRED);
   assign warning       = ((r_state == RUNNING) || (r_state == PAUSED))
                          && (r_time != 16'd0) && (r_time <= T_WARN);

endmodule
